// File: rtl/oh_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : oh_skid_buffer
// Description : Two-entry registered valid/ready pipeline stage. Every output
//               (in_ready, out_valid, out_data, count) comes straight from a
//               flop, so neither the forward data/valid path nor the backward
//               ready path is combinational through this stage. Sustains one
//               transfer per cycle with no bubbles.
//
// Ports       : clk        - clock, all logic on rising edge
//               nreset     - synchronous active-low reset
//               in_valid   - upstream data valid
//               in_data    - upstream data [N-1:0]
//               in_ready   - stage can accept (registered, depends on state only)
//               out_valid  - output data valid (registered)
//               out_data   - output data [N-1:0] (registered, main entry)
//               out_ready  - downstream accepts
//               count      - occupancy 0..2 (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module oh_skid_buffer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    // State encoding: value equals the number of stored entries.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [N-1:0] r_main;
    logic [N-1:0] w_main_nxt;
    logic [N-1:0] r_skid;
    logic [N-1:0] w_skid_nxt;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [1:0]   r_count;
    logic         w_in_xfer;
    logic         w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // Next-state and datapath selection.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            c_st_empty: begin
                if (w_in_xfer) begin
                    w_state_nxt = c_st_one;
                    w_main_nxt  = in_data;
                end
            end
            c_st_one: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_nxt = in_data;
                end else if (w_in_xfer) begin
                    // Main is stalled; park the new word in the skid slot.
                    w_state_nxt = c_st_full;
                    w_skid_nxt  = in_data;
                end else if (w_out_xfer) begin
                    w_state_nxt = c_st_empty;
                end
            end
            c_st_full: begin
                // in_ready is low here, so only the drain case exists.
                if (w_out_xfer) begin
                    w_state_nxt = c_st_one;
                    w_main_nxt  = r_skid;
                end
            end
            default: begin
                w_state_nxt = c_st_empty;
            end
        endcase
    end

    // Status outputs are registered from the next state so they are
    // glitch-free flop outputs yet reflect the new state in the same cycle.
    // in_ready stays low through reset and rises one edge after release.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= c_st_empty;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != c_st_full);
            r_out_valid <= (w_state_nxt != c_st_empty);
            r_count     <= w_state_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_oh_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oh_skid_buffer
// Description : Directed and random-stall bench for oh_skid_buffer, with a
//               32-bit instance and a 1-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oh_skid_buffer;

    logic        clk;
    logic        nreset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  count;

    logic        in_valid1;
    logic [0:0]  in_data1;
    logic        in_ready1;
    logic        out_valid1;
    logic [0:0]  out_data1;
    logic        out_ready1;
    logic [1:0]  count1;

    int tests;
    int fails;

    oh_skid_buffer #(.N(32)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    oh_skid_buffer #(.N(1)) dut1 (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .in_ready  (in_ready1),
        .out_valid (out_valid1),
        .out_data  (out_data1),
        .out_ready (out_ready1),
        .count     (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 2'd0) begin
                fails++;
                $display("FAIL reset_hold: vld=%b rdy=%b cnt=%0d expected 0 0 0",
                         out_valid, in_ready, count);
            end
        end
        nreset = 1'b1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_pre: in_ready=%b expected 0", in_ready);
        end
        step();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 2'd0) begin
            fails++;
            $display("FAIL reset_release_post: rdy=%b vld=%b cnt=%0d expected 1 0 0",
                     in_ready, out_valid, count);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h11 || count !== 2'd1) begin
            fails++;
            $display("FAIL single_out: vld=%b data=%0h cnt=%0d expected 1 11 1",
                     out_valid, out_data, count);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            fails++;
            $display("FAIL single_drain: vld=%b cnt=%0d expected 0 0", out_valid, count);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_ready[%0d]: in_ready=%b expected 1", i, in_ready);
            end
            step();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) || count !== 2'd1) begin
                fails++;
                $display("FAIL stream_out[%0d]: vld=%b data=%0h cnt=%0d expected 1 %0h 1",
                         i, out_valid, out_data, count, i);
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            fails++;
            $display("FAIL stream_drain: vld=%b cnt=%0d expected 0 0", out_valid, count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAA;
        step();
        in_data = 32'hBB;
        step();
        tests++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAA || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_full: cnt=%0d rdy=%b data=%0h vld=%b expected 2 0 aa 1",
                     count, in_ready, out_data, out_valid);
        end
        in_data = 32'hCC;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAA) begin
                fails++;
                $display("FAIL bp_hold[%0d]: cnt=%0d rdy=%b data=%0h expected 2 0 aa",
                         i, count, in_ready, out_data);
            end
        end
        out_ready = 1'b1;
        step();
        tests++;
        if (out_data !== 32'hBB || count !== 2'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_drain_bb: data=%0h cnt=%0d rdy=%b expected bb 1 1",
                     out_data, count, in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_data !== 32'hCC || count !== 2'd1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_drain_cc: data=%0h cnt=%0d vld=%b expected cc 1 1",
                     out_data, count, out_valid);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            fails++;
            $display("FAIL bp_empty: vld=%b cnt=%0d expected 0 0", out_valid, count);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        step();
        in_data = 32'h66;
        step();
        in_valid = 1'b0;
        tests++;
        if (count !== 2'd2) begin
            fails++;
            $display("FAIL rf_fill: cnt=%0d expected 2", count);
        end
        nreset    = 1'b0;
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rf_reset: vld=%b cnt=%0d rdy=%b expected 0 0 0",
                     out_valid, count, in_ready);
        end
        nreset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rf_no_ghost[%0d]: vld=%b data=%0h expected vld 0",
                         i, out_valid, out_data);
            end
        end
        in_valid = 1'b1;
        in_data  = 32'h77;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h77) begin
            fails++;
            $display("FAIL rf_after: vld=%b data=%0h expected 1 77", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_random_stall();
        logic [31:0] q0[$];
        logic [0:0]  q1[$];
        int          got0;
        int          got1;
        int          cyc;
        logic        hold0;
        logic        hold1;
        logic        stall0;
        logic        stall1;
        logic [31:0] sd0;
        logic [0:0]  sd1;
        logic [31:0] exp0;
        logic [0:0]  exp1;
        got0 = 0; got1 = 0; cyc = 0;
        hold0 = 1'b0; hold1 = 1'b0;
        while ((got0 < 10000 || got1 < 10000) && cyc < 60000) begin
            if (!hold0) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            if (!hold1) begin
                in_valid1 = 1'($urandom_range(0, 1));
                in_data1  = 1'($urandom_range(0, 1));
            end
            out_ready  = 1'($urandom_range(0, 1));
            out_ready1 = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                exp0 = (q0.size() > 0) ? q0.pop_front() : 32'hDEAD_BEEF;
                tests++;
                if (out_data !== exp0) begin
                    fails++;
                    $display("FAIL rnd32_order[%0d]: got %0h expected %0h", got0, out_data, exp0);
                end
                got0++;
            end
            if (out_valid1 && out_ready1) begin
                exp1 = (q1.size() > 0) ? q1.pop_front() : 1'bx;
                tests++;
                if (out_data1 !== exp1) begin
                    fails++;
                    $display("FAIL rnd1_order[%0d]: got %b expected %b", got1, out_data1, exp1);
                end
                got1++;
            end
            if (in_valid && in_ready)   q0.push_back(in_data);
            if (in_valid1 && in_ready1) q1.push_back(in_data1);
            hold0  = in_valid & ~in_ready;
            hold1  = in_valid1 & ~in_ready1;
            stall0 = out_valid & ~out_ready;
            stall1 = out_valid1 & ~out_ready1;
            sd0    = out_data;
            sd1    = out_data1;
            step();
            cyc++;
            tests++;
            if (count > 2'd2 || int'(count) != q0.size()) begin
                fails++;
                $display("FAIL rnd32_count: cnt=%0d expected %0d", count, q0.size());
            end
            tests++;
            if (count1 > 2'd2 || int'(count1) != q1.size()) begin
                fails++;
                $display("FAIL rnd1_count: cnt=%0d expected %0d", count1, q1.size());
            end
            if (stall0) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== sd0) begin
                    fails++;
                    $display("FAIL rnd32_stable: vld=%b data=%0h expected 1 %0h",
                             out_valid, out_data, sd0);
                end
            end
            if (stall1) begin
                tests++;
                if (out_valid1 !== 1'b1 || out_data1 !== sd1) begin
                    fails++;
                    $display("FAIL rnd1_stable: vld=%b data=%b expected 1 %b",
                             out_valid1, out_data1, sd1);
                end
            end
        end
        tests++;
        if (got0 < 10000 || got1 < 10000) begin
            fails++;
            $display("FAIL rnd_timeout: got %0d/%0d transfers expected 10000 each", got0, got1);
        end
        in_valid   = 1'b0;
        in_valid1  = 1'b0;
        out_ready  = 1'b1;
        out_ready1 = 1'b1;
        step();
        step();
        step();
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        nreset     = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_reset_full();
        test_random_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
